// File: rtl/l1_dcache_if.sv
// Bundle of pipeline-side and memory-side signals of the L1 data cache.
// The cache side uses the slave modport; pipeline plus memory use master.
interface l1_dcache_if #(
   parameter int LINE_BITS = 256
);
   logic                 p1_req_i;
   logic                 p1_write_i;
   logic [31:0]          p1_addr_i;
   logic [31:0]          p1_data_i;
   logic [31:0]          p1_data_o;
   logic                 p1_stall_o;
   logic                 mem_req_o;
   logic                 mem_write_o;
   logic [31:0]          mem_addr_o;
   logic [LINE_BITS-1:0] mem_data_o;
   logic [LINE_BITS-1:0] mem_data_i;
   logic                 mem_ack_i;

   // Handshakes: the pipeline holds p1_* stable while p1_stall_o=1 and the
   // access completes in the first cycle p1_req_i=1 with p1_stall_o=0.
   // mem_req_o and every mem_* output stay stable until mem_ack_i is sampled
   // high at a rising edge; mem_ack_i is a one-cycle pulse, ignored when
   // mem_req_o=0.
   modport slave (
      input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
      output p1_data_o, p1_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
   );

   modport master (
      output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
      input  p1_data_o, p1_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache. Hits complete
// combinationally; misses stall the pipeline while a victim is written back and the line refilled.
module l1_dcache #(
   parameter int LINES     = 32,
   parameter int LINE_BITS = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   l1_dcache_if.slave  bus,
   output logic [1:0]  state_dbg
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 32 - 5 - IW;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;

   state_e                state;
   logic [LINES-1:0]      valid;
   logic [LINES-1:0]      dirty;
   logic [TW-1:0]         tag_arr  [LINES];
   logic [LINE_BITS-1:0]  data_arr [LINES];

   logic [IW-1:0]         idx;
   logic [TW-1:0]         req_tag;
   logic [2:0]            word;
   logic                  hit;
   logic                  store_hit;
   logic [LINE_BITS-1:0]  cur_line;
   logic                  unused_addr_bits;

   assign idx              = bus.p1_addr_i[5+IW-1:5];
   assign req_tag          = bus.p1_addr_i[31:5+IW];
   assign word             = bus.p1_addr_i[4:2];
   assign unused_addr_bits = ^bus.p1_addr_i[1:0];
   assign cur_line         = data_arr[idx];

   assign hit       = bus.p1_req_i & valid[idx] & (tag_arr[idx] == req_tag);
   assign store_hit = (state == IDLE) & hit & bus.p1_write_i;

   assign bus.p1_data_o  = hit ? cur_line[{word, 5'b0} +: 32] : 32'h0;
   assign bus.p1_stall_o = (bus.p1_req_i & ~hit) | (state != IDLE);
   assign state_dbg      = state;

   // Control state and memory-side outputs; the mem_* outputs are loaded on
   // the edge that enters a state so they are stable for the whole request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= IDLE;
         valid           <= '0;
         dirty           <= '0;
         bus.mem_req_o   <= 1'b0;
         bus.mem_write_o <= 1'b0;
         bus.mem_addr_o  <= 32'h0;
         bus.mem_data_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (store_hit) begin
                  dirty[idx] <= 1'b1;
               end else if (bus.p1_req_i && !hit) begin
                  bus.mem_req_o <= 1'b1;
                  if (valid[idx] && dirty[idx]) begin
                     state           <= WRITEBACK;
                     bus.mem_write_o <= 1'b1;
                     bus.mem_addr_o  <= {tag_arr[idx], idx, 5'b0};
                     bus.mem_data_o  <= cur_line;
                  end else begin
                     state           <= REFILL;
                     bus.mem_write_o <= 1'b0;
                     bus.mem_addr_o  <= {req_tag, idx, 5'b0};
                     bus.mem_data_o  <= '0;
                  end
               end
            end
            WRITEBACK: begin
               if (bus.mem_ack_i) begin
                  state           <= REFILL;
                  dirty[idx]      <= 1'b0;
                  bus.mem_write_o <= 1'b0;
                  bus.mem_addr_o  <= {req_tag, idx, 5'b0};
                  bus.mem_data_o  <= '0;
               end
            end
            REFILL: begin
               if (bus.mem_ack_i) begin
                  state           <= IDLE;
                  valid[idx]      <= 1'b1;
                  dirty[idx]      <= 1'b0;
                  bus.mem_req_o   <= 1'b0;
                  bus.mem_write_o <= 1'b0;
                  bus.mem_addr_o  <= 32'h0;
                  bus.mem_data_o  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data storage carry no reset; valid bits gate every use of them.
   always_ff @(posedge clk_i) begin
      if (store_hit) begin
         data_arr[idx][{word, 5'b0} +: 32] <= bus.p1_data_i;
      end else if (state == REFILL && bus.mem_ack_i) begin
         data_arr[idx] <= bus.mem_data_i;
         tag_arr[idx]  <= req_tag;
      end
   end
endmodule

// File: tb/tb_l1_dcache.sv
// Randomized self-checking bench for l1_dcache against a flat-memory
// reference plus a per-index occupancy model of the cache.
module tb_l1_dcache;
   localparam int LINES = 32;
   localparam int IW    = 5;
   localparam int TW    = 22;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   l1_dcache_if #(.LINE_BITS(256)) bus ();

   l1_dcache #(.LINES(LINES), .LINE_BITS(256)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference: architectural memory = stores not yet seen by backing memory
   // overlaid on the backing memory the bench itself plays.
   logic [31:0]  ref_mem [logic [31:0]];
   logic [255:0] bmem    [logic [26:0]];
   bit           m_valid [LINES];
   bit           m_dirty [LINES];
   logic [TW-1:0] m_tag  [LINES];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return 32'h0F0 + (a >> 2);
   endfunction

   function automatic logic [255:0] bmem_line(input logic [26:0] la);
      logic [255:0] l;
      if (bmem.exists(la)) return bmem[la];
      for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word({la, 3'(w), 2'b00});
      return l;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [255:0] l;
      if (ref_mem.exists(a)) return ref_mem[a];
      l = bmem_line(a[31:5]);
      return l[{a[4:2], 5'b0} +: 32];
   endfunction

   function automatic logic [255:0] ref_line(input logic [26:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_word({la, 3'(w), 2'b00});
      return l;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      ref_mem.delete();
   endtask

   // Called just after the negedge of the first cycle a request should be
   // visible; returns just after the negedge following the ack.
   task automatic serve(input bit exp_wr, input logic [31:0] exp_addr,
                        input logic [255:0] exp_data, input int lat_in);
      int lat;
      lat = (lat_in == 0) ? int'($urandom_range(1, 4)) : lat_in;
      check("mem_req", bus.mem_req_o, 1'b1);
      check("mem_write", bus.mem_write_o, exp_wr);
      check("mem_addr", bus.mem_addr_o, exp_addr);
      if (exp_wr) check("wb_data", bus.mem_data_o, exp_data);
      for (int i = 1; i < lat; i++) begin
         @(negedge clk); #1;
         check("mem_req_hold", bus.mem_req_o, 1'b1);
         check("mem_addr_hold", bus.mem_addr_o, exp_addr);
         check("stall_hold", bus.p1_stall_o, 1'b1);
      end
      bus.mem_ack_i = 1'b1;
      if (exp_wr) bmem[exp_addr[31:5]] = bus.mem_data_o;
      else bus.mem_data_i = bmem_line(exp_addr[31:5]);
      @(negedge clk);
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = {8{$urandom()}};
      #1;
   endtask

   task automatic access(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
      logic [IW-1:0] idx;
      logic [TW-1:0] tg;
      bit            hit;
      idx = addr[5+IW-1:5];
      tg  = addr[31:5+IW];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      @(negedge clk);
      bus.p1_req_i   = 1'b1;
      bus.p1_write_i = wr;
      bus.p1_addr_i  = addr;
      bus.p1_data_i  = wdata;
      #1;
      check("stall_entry", bus.p1_stall_o, !hit);
      check("mem_req_entry", bus.mem_req_o, 1'b0);
      if (!hit) begin
         @(negedge clk); #1;
         if (m_valid[idx] && m_dirty[idx]) begin
            serve(1'b1, {m_tag[idx], idx, 5'b0}, ref_line({m_tag[idx], idx}), 0);
            m_dirty[idx] = 1'b0;
         end
         serve(1'b0, {tg, idx, 5'b0}, '0, lat);
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         check("stall_release", bus.p1_stall_o, 1'b0);
         check("mem_req_done", bus.mem_req_o, 1'b0);
      end
      if (!wr) begin
         check("load_data", bus.p1_data_o, ref_word(addr));
      end else begin
         ref_mem[addr] = wdata;
         m_dirty[idx]  = 1'b1;
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      bus.p1_req_i = 1'b0;
      #1;
      check("idle_stall", bus.p1_stall_o, 1'b0);
      check("idle_mem_req", bus.mem_req_o, 1'b0);
   endtask

   initial begin
      bus.p1_req_i   = 1'b0;
      bus.p1_write_i = 1'b0;
      bus.p1_addr_i  = 32'h0;
      bus.p1_data_i  = 32'h0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      model_reset();
      #2 rst = 1'b1;
      #10;
      check("rst_mem_req", bus.mem_req_o, 1'b0);
      check("rst_mem_write", bus.mem_write_o, 1'b0);
      check("rst_mem_addr", bus.mem_addr_o, 32'h0);
      check("rst_mem_data", bus.mem_data_o, 256'h0);
      check("rst_stall_noreq", bus.p1_stall_o, 1'b0);
      bus.p1_req_i  = 1'b1;
      bus.p1_addr_i = 32'h40;
      #1;
      check("rst_stall_req", bus.p1_stall_o, 1'b1);
      check("rst_data", bus.p1_data_o, 32'h0);
      bus.p1_req_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // cold load, latency 10, line word i = 0x100+i
      access(1'b0, 32'h40, 32'h0, 10);
      check("cold_load_const", bus.p1_data_o, 32'h100);
      access(1'b0, 32'h4C, 32'h0, 0);
      check("hit_load_const", bus.p1_data_o, 32'h103);

      // dirty eviction of index 2
      access(1'b1, 32'h44, 32'hDEADBEEF, 0);
      access(1'b0, 32'h444, 32'h0, 0);
      check("evicted_word1", bmem[27'h2][63:32], 32'hDEADBEEF);
      check("evicted_word0", bmem[27'h2][31:0], 32'h100);

      // store miss to a clean line, then evict it
      access(1'b1, 32'h1000, 32'h1234_5678, 0);
      access(1'b0, 32'h1400, 32'h0, 0);
      check("store_miss_wb", bmem[27'h80][31:0], 32'h1234_5678);

      // reset in the middle of a refill, then a late ack
      @(negedge clk);
      bus.p1_req_i   = 1'b1;
      bus.p1_write_i = 1'b0;
      bus.p1_addr_i  = 32'h2020;
      @(negedge clk); #1;
      check("pre_rst_req", bus.mem_req_o, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_mid_req", bus.mem_req_o, 1'b0);
      check("rst_mid_addr", bus.mem_addr_o, 32'h0);
      check("rst_mid_stall", bus.p1_stall_o, 1'b1);
      bus.p1_req_i   = 1'b0;
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = {8{32'hBAD0BAD0}};
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      check("late_ack_req", bus.mem_req_o, 1'b0);
      check("late_ack_stall", bus.p1_stall_o, 1'b0);
      model_reset();
      access(1'b0, 32'h2020, 32'h0, 0);
      access(1'b0, 32'h40, 32'h0, 0);

      // ack pulse while idle with no request
      @(negedge clk);
      bus.p1_req_i   = 1'b0;
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = {8{32'hFFFF0000}};
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      check("idle_ack_req", bus.mem_req_o, 1'b0);
      check("idle_ack_write", bus.mem_write_o, 1'b0);
      check("idle_ack_addr", bus.mem_addr_o, 32'h0);
      check("idle_ack_data", bus.mem_data_o, 256'h0);
      check("idle_ack_stall", bus.p1_stall_o, 1'b0);
      check("idle_ack_p1data", bus.p1_data_o, 32'h0);
      access(1'b0, 32'h40, 32'h0, 0);

      // randomized traffic over a few tags and indexes to force conflicts
      for (int n = 0; n < 400; n++) begin
         logic [TW-1:0] tg;
         logic [IW-1:0] ix;
         logic [2:0]    w;
         tg = TW'($urandom_range(0, 3));
         ix = IW'($urandom_range(0, 7));
         w  = 3'($urandom_range(0, 7));
         access(1'($urandom_range(0, 1)), {tg, ix, w, 2'b00}, $urandom(), 0);
         if ($urandom_range(0, 7) == 0) idle_cycle();
      end
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
